// File: rtl/logic_basic_pkg.sv
// Shared types and helpers for the logic_basic stream blocks.
// Holds the downsizer FSM state type and the beat-to-slice mapping.
package logic_basic_pkg;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_DATA = 1'b1
    } fsm_state_e;

    // Slice of the wide word that carries beat k, for either beat ordering.
    function automatic int unsigned slice_index(input int unsigned k,
                                                input int unsigned ratio,
                                                input bit          msb_first);
        return msb_first ? (ratio - 1 - k) : k;
    endfunction

endpackage

// File: rtl/logic_basic_downsizer.sv
// Stream width downsizer: one RATIO*WIDTH-bit rx word becomes RATIO WIDTH-bit tx beats.
// Define LOGIC_BASIC_DOWNSIZER_MSB_FIRST_EN to send the most significant slice first.
//
// Handshake: a transfer happens on a rising aclk edge where valid && ready on that side.
// tx_tvalid never depends on tx_tready; rx_tready depends combinationally on tx_tready so
// a new word is taken on the same edge the last beat of the current word leaves.
module logic_basic_downsizer
    import logic_basic_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int RATIO         = 4,
    parameter int COUNTER_WIDTH = $clog2(RATIO)
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    input  logic                     rx_tvalid,
    input  logic [WIDTH*RATIO-1:0]   rx_tdata,
    output logic                     rx_tready,
    input  logic                     tx_tready,
    output logic                     tx_tvalid,
    output logic [WIDTH-1:0]         tx_tdata,
    output logic                     debug_state
);

    localparam int DATA_W = WIDTH * RATIO;

`ifdef LOGIC_BASIC_DOWNSIZER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam int unsigned              OUT_SLICE = slice_index(0, RATIO, MSB_FIRST);
    localparam logic [COUNTER_WIDTH-1:0] LAST_BEAT = COUNTER_WIDTH'(RATIO - 1);

    if (WIDTH < 1) begin : g_drc_width
        $error("logic_basic_downsizer: WIDTH must be >= 1");
    end
    if (RATIO < 2) begin : g_drc_ratio
        $error("logic_basic_downsizer: RATIO must be >= 2");
    end

    fsm_state_e               state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [DATA_W-1:0]        hold_q, hold_d;
    logic [DATA_W-1:0]        hold_shifted;
    logic                     ready_en_q;
    logic                     last;
    logic                     rx_hs;
    logic                     tx_hs;

    assign last        = (count_q == LAST_BEAT);
    assign tx_tvalid   = (state_q == FSM_DATA);
    assign rx_tready   = ready_en_q && ((state_q == FSM_IDLE) ||
                                        ((state_q == FSM_DATA) && last && tx_tready));
    assign rx_hs       = rx_tvalid && rx_tready;
    assign tx_hs       = tx_tvalid && tx_tready;
    assign tx_tdata    = hold_q[OUT_SLICE*WIDTH +: WIDTH];
    assign debug_state = state_q;

    // Move the next slice into the output position.
`ifdef LOGIC_BASIC_DOWNSIZER_MSB_FIRST_EN
    assign hold_shifted = {hold_q[DATA_W-WIDTH-1:0], {WIDTH{1'b0}}};
`else
    assign hold_shifted = {{WIDTH{1'b0}}, hold_q[DATA_W-1:WIDTH]};
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hold_d  = hold_q;
        if (rx_hs) begin
            hold_d  = rx_tdata;
            count_d = '0;
            state_d = FSM_DATA;
        end else if (tx_hs) begin
            // The register is left untouched after the last beat so tx_tdata keeps its value.
            if (last) begin
                count_d = '0;
                state_d = FSM_IDLE;
            end else begin
                count_d = count_q + COUNTER_WIDTH'(1);
                hold_d  = hold_shifted;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= FSM_IDLE;
            count_q    <= '0;
            hold_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef OVL_ASSERT_ON
    a_count_range : assert property (@(posedge aclk) disable iff (!areset_n)
        int'(count_q) < RATIO);
    a_tx_hold : assert property (@(posedge aclk) disable iff (!areset_n)
        (tx_tvalid && !tx_tready) |=> (tx_tvalid && $stable(tx_tdata)));
`endif

endmodule
